// File: rtl/tt_um_ternary_pkg.sv
// tt_um_ternary_pkg
// Shared definitions for the ternary matrix-vector multiply scheduler:
// FSM state encoding, accumulator width, ternary weight codes, cfg_param
// field layout and the two accumulator-to-byte reduction helpers.
package tt_um_ternary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // 16 rows of |act| <= 128 reach at most +/-2048, which needs 13 signed bits.
  localparam int ACC_W = 13;

  // Ternary weight codes; 2'b00 and 2'b10 both mean "zero".
  localparam logic [1:0] W_POS = 2'b01;
  localparam logic [1:0] W_NEG = 2'b11;

  // cfg_param = {in_len-1, out_len-1}
  localparam int CFG_W       = 7;
  localparam int CFG_IN_LSB  = 3;
  localparam int CFG_IN_W    = 4;
  localparam int CFG_OUT_LSB = 0;
  localparam int CFG_OUT_W   = 3;
  localparam logic [CFG_W-1:0] CFG_RESET = 7'h7F;

  // Clamp a signed accumulator into the signed byte range.
  function automatic logic [7:0] reduce_sat(input logic signed [ACC_W-1:0] a);
    if (a > 13'sd127) begin
      return 8'h7F;
    end else if (a < -13'sd128) begin
      return 8'h80;
    end else begin
      return a[7:0];
    end
  endfunction

  // Keep the low byte (two's-complement wrap).
  function automatic logic [7:0] reduce_wrap(input logic signed [ACC_W-1:0] a);
    return a[7:0];
  endfunction

endpackage

// File: rtl/tt_um_mult_lane.sv
// tt_um_mult_lane
// One output lane of the ternary multiplier: a single signed accumulator
// that adds, subtracts or ignores each activation according to its weight.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr            synchronous clear (start of a new multiply)
//   en             activation handshake for this lane
//   weight [1:0]   ternary weight for the current row
//   act    [7:0]   signed activation
//   acc    [12:0]  signed accumulator value
module tt_um_mult_lane
  import tt_um_ternary_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       weight,
  input  logic [7:0]       act,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] act_ext;
  assign act_ext = {{(ACC_W-8){act[7]}}, act};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      if (weight == W_POS) begin
        acc <= acc + act_ext;
      end else if (weight == W_NEG) begin
        acc <= acc - act_ext;
      end
    end
  end

endmodule

// File: rtl/tt_um_mult_sched.sv
// tt_um_mult_sched
// Ternary matrix-vector multiply scheduler. A start request latches the
// vector lengths, an activation stream is accumulated into MAX_OUT_LEN
// lanes (one row per handshake), then the lane results are streamed out.
// Optional build macro: MULT_SATURATE_EN -- results are clamped to a signed
// byte instead of wrapping.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, cfg_param[6:0]       begin request, {in_len-1, out_len-1}
//   weights                     ternary matrix, weight(i,j) at 2*(i*MAX_OUT_LEN+j)
//   act_valid/act_data/act_ready  activation stream in
//   res_valid/res_data/res_idx/res_ready  result stream out
//   busy, done                  not idle, one-cycle completion pulse
module tt_um_mult_sched
  import tt_um_ternary_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [6:0]                        cfg_param,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights,
  input  logic                              act_valid,
  input  logic [7:0]                        act_data,
  output logic                              act_ready,
  output logic                              res_valid,
  output logic [7:0]                        res_data,
  output logic [2:0]                        res_idx,
  input  logic                              res_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int RW = (MAX_IN_LEN  > 1) ? $clog2(MAX_IN_LEN)  : 1;
  localparam int LW = (MAX_OUT_LEN > 1) ? $clog2(MAX_OUT_LEN) : 1;

  state_t            state_reg, state_next;
  logic [CFG_W-1:0]  cfg_reg;
  logic [RW-1:0]     row_reg;
  logic [LW-1:0]     lane_reg;
  logic              done_reg;

  logic [CFG_IN_W-1:0]  in_m1;
  logic [CFG_OUT_W-1:0] out_m1;
  logic start_fire, act_fire, res_fire, last_row, last_lane;

  assign in_m1  = cfg_reg[CFG_IN_LSB  +: CFG_IN_W];
  assign out_m1 = cfg_reg[CFG_OUT_LSB +: CFG_OUT_W];

  assign start_fire = start && (state_reg == ST_IDLE);
  assign act_fire   = act_valid && act_ready;
  assign res_fire   = res_valid && res_ready;
  assign last_row   = (row_reg  == RW'(in_m1));
  assign last_lane  = (lane_reg == LW'(out_m1));

  // Next state and handshake readiness.
  always_comb begin
    state_next = state_reg;
    act_ready  = 1'b0;
    res_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_MULT;
      end
      ST_MULT: begin
        act_ready = 1'b1;
        if (act_valid && last_row) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        res_valid = 1'b1;
        if (res_ready && last_lane) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cfg_reg   <= CFG_RESET;
      row_reg   <= '0;
      lane_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      if (start_fire) begin
        cfg_reg  <= cfg_param;
        row_reg  <= '0;
        lane_reg <= '0;
      end
      // Row counter stays on the last row; the next start rewinds it.
      if (act_fire && !last_row) begin
        row_reg <= row_reg + 1'b1;
      end
      if (res_fire) begin
        if (last_lane) begin
          done_reg <= 1'b1;
          lane_reg <= '0;
        end else begin
          lane_reg <= lane_reg + 1'b1;
        end
      end
    end
  end

  // Reshape the flat weight bus into [row][lane] for clean row indexing.
  logic [1:0] w_mat [MAX_IN_LEN][MAX_OUT_LEN];

  genvar gi, gj;
  generate
    for (gi = 0; gi < MAX_IN_LEN; gi++) begin : g_row
      for (gj = 0; gj < MAX_OUT_LEN; gj++) begin : g_col
        assign w_mat[gi][gj] = weights[2*(gi*MAX_OUT_LEN+gj) +: 2];
      end
    end
  endgenerate

  logic [ACC_W-1:0] acc_arr [MAX_OUT_LEN];

  generate
    for (gi = 0; gi < MAX_OUT_LEN; gi++) begin : g_lane
      logic lane_en;
      // Lanes beyond out_len-1 are cleared at start and never enabled.
      assign lane_en = act_fire && (gi <= int'(out_m1));

      tt_um_mult_lane u_lane (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_fire),
        .en     (lane_en),
        .weight (w_mat[row_reg][gi]),
        .act    (act_data),
        .acc    (acc_arr[gi])
      );
    end
  endgenerate

  logic [7:0] red_data;
`ifdef MULT_SATURATE_EN
  assign red_data = reduce_sat($signed(acc_arr[lane_reg]));
`else
  assign red_data = reduce_wrap($signed(acc_arr[lane_reg]));
`endif

  // Result outputs read zero whenever no result is being offered.
  assign res_data = res_valid ? red_data : 8'h00;
  assign res_idx  = res_valid ? 3'(lane_reg) : 3'd0;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_tt_um_mult_sched.sv
module tb_tt_um_mult_sched;

  localparam int MI = 16;
  localparam int MO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [6:0]        cfg_param;
  logic [2*MI*MO-1:0] weights;
  logic              act_valid;
  logic [7:0]        act_data;
  logic              act_ready;
  logic              res_valid;
  logic [7:0]        res_data;
  logic [2:0]        res_idx;
  logic              res_ready;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;
  int acts [MI];

  tt_um_mult_sched #(.MAX_IN_LEN(MI), .MAX_OUT_LEN(MO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_param (cfg_param),
    .weights   (weights),
    .act_valid (act_valid),
    .act_data  (act_data),
    .act_ready (act_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int wt(input int i, input int j);
    return int'(weights[2*(i*MO+j) +: 2]);
  endfunction

  // Dot product of the first in_len activations with column j.
  function automatic int model_acc(input int j, input int in_len);
    int s = 0;
    for (int i = 0; i < in_len; i++) begin
      if (wt(i, j) == 1) s += acts[i];
      else if (wt(i, j) == 3) s -= acts[i];
    end
    return s;
  endfunction

  // Expected output byte as an unsigned 0..255 value.
  function automatic int reduce8(input int v);
    int r = v;
`ifdef MULT_SATURATE_EN
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`endif
    return r & 255;
  endfunction

  task automatic rand_weights();
    for (int k = 0; k < (2*MI*MO)/32; k++) weights[32*k +: 32] = $urandom();
  endtask

  task automatic rand_acts();
    for (int i = 0; i < MI; i++) acts[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic set_w(input int i, input int j, input logic [1:0] v);
    weights[2*(i*MO+j) +: 2] = v;
  endtask

  // Full operation starting at a negedge; returns at the negedge where done
  // must be high, so the caller can chain a start into the done cycle.
  task automatic run_op(input logic [6:0] cfg, input int gap_pct, input int stall_pct,
                        input int long_stall_at, input bit mid_start, input string tag);
    int in_len  = int'(cfg[6:3]) + 1;
    int out_len = int'(cfg[2:0]) + 1;
    int exp_b [MO];
    int nst;
    for (int j = 0; j < MO; j++) exp_b[j] = reduce8(model_acc(j, in_len));

    start = 1'b1; cfg_param = cfg;
    @(negedge clk);
    start = 1'b0; cfg_param = 7'($urandom());
    chk({tag, "_start_busy"}, 32'(busy), 1);
    chk({tag, "_start_act_ready"}, 32'(act_ready), 1);
    chk({tag, "_start_done"}, 32'(done), 0);

    for (int i = 0; i < in_len; i++) begin
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          act_valid = 1'b0; act_data = 8'($urandom());
          @(negedge clk);
          chk({tag, "_gap_act_ready"}, 32'(act_ready), 1);
        end
      end
      act_valid = 1'b1; act_data = 8'(acts[i]);
      if (mid_start && i == 1) begin
        start = 1'b1; cfg_param = ~cfg;
      end
      @(negedge clk);
      $display("%s act row=%0d data=%0d", tag, i, acts[i]);
      start = 1'b0; act_valid = 1'b0;
    end

    chk({tag, "_drain_res_valid"}, 32'(res_valid), 1);
    chk({tag, "_drain_act_ready"}, 32'(act_ready), 0);

    for (int j = 0; j < out_len; j++) begin
      chk({tag, "_res_valid"}, 32'(res_valid), 1);
      chk({tag, "_res_idx"}, 32'(res_idx), j);
      chk({tag, "_res_data"}, 32'(res_data), exp_b[j]);
      if (j == long_stall_at) nst = 5;
      else if (int'($urandom_range(0, 99)) < stall_pct) nst = int'($urandom_range(1, 3));
      else nst = 0;
      repeat (nst) begin
        res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_stall_valid"}, 32'(res_valid), 1);
        chk({tag, "_stall_idx"}, 32'(res_idx), j);
        chk({tag, "_stall_data"}, 32'(res_data), exp_b[j]);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      $display("%s result idx=%0d data=0x%02h stalls=%0d", tag, j, exp_b[j][7:0], nst);
      if (j < out_len - 1) chk({tag, "_early_done"}, 32'(done), 0);
    end

    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_end_busy"}, 32'(busy), 0);
    chk({tag, "_end_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_end_act_ready"}, 32'(act_ready), 0);
  endtask

  initial begin
    int saw_done;
    rst = 1'b1; start = 1'b0; cfg_param = '0; weights = '0;
    act_valid = 1'b0; act_data = '0; res_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_act_ready", 32'(act_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_idx", 32'(res_idx), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // All +1 weights, sixteen activations of 5 -> 80 in every lane
    for (int i = 0; i < MI; i++) begin
      acts[i] = 5;
      for (int j = 0; j < MO; j++) set_w(i, j, 2'b01);
    end
    run_op(7'h7F, 0, 0, -1, 1'b0, "full");
    @(negedge clk);
    chk("full_done_pulse", 32'(done), 0);

    // Lane 0 all -1 weights, activations -128 -> 2048 (wrap 0 / clamp 127)
    weights = '0;
    for (int i = 0; i < MI; i++) begin
      acts[i] = -128;
      set_w(i, 0, 2'b11);
    end
    run_op(7'h78, 0, 0, -1, 1'b0, "ovf");
    @(negedge clk);

    // Two rows, two lanes
    weights = '0;
    set_w(0, 0, 2'b01); set_w(0, 1, 2'b11);
    set_w(1, 0, 2'b10); set_w(1, 1, 2'b01);
    acts[0] = 7; acts[1] = -3;
    run_op({4'd1, 3'd1}, 0, 0, -1, 1'b0, "small");
    @(negedge clk);

    // Gapped activations and a 5-cycle result stall
    rand_weights(); rand_acts();
    run_op(7'h7F, 40, 30, 2, 1'b0, "stall");
    @(negedge clk);

    // Start during MULT ignored; start in the done cycle accepted
    rand_weights(); rand_acts();
    run_op(7'h5B, 20, 20, -1, 1'b1, "midstart");
    rand_acts();
    run_op(7'h33, 20, 20, -1, 1'b0, "chain");
    @(negedge clk);
    chk("chain_done_pulse", 32'(done), 0);

    // Reset in the middle of MULT after three activations
    rand_weights(); rand_acts();
    start = 1'b1; cfg_param = 7'h7F;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      act_valid = 1'b1; act_data = 8'(acts[i]);
      @(negedge clk);
      $display("abort act row=%0d data=%0d", i, acts[i]);
    end
    act_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_act_ready", 32'(act_ready), 0);
    chk("abort_res_valid", 32'(res_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done++;
    end
    chk("abort_no_done", 32'(saw_done), 0);
    rand_acts();
    run_op(7'h7F, 10, 10, -1, 1'b0, "fresh");
    @(negedge clk);

    // Randomized operations
    for (int n = 0; n < 15; n++) begin
      rand_weights(); rand_acts();
      run_op(7'($urandom_range(0, 127)), 25, 25, -1, 1'($urandom_range(0, 1)), "rnd");
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
